// File: rtl/tile_game_pkg.sv
// Shared game constants and state encoding for the tile grid.
// Grid is 4x3 tiles of 160x160 pixels.
package tile_game_pkg;

   localparam int TILE_W          = 160;
   localparam int TILE_H          = 160;
   localparam int GRID_COLS       = 4;
   localparam int GRID_ROWS       = 3;
   localparam int TILES           = GRID_COLS * GRID_ROWS;
   localparam int FADE_STEPS      = 16;
   localparam int FRAMES_PER_STEP = 2;
   localparam int PEND_MAX        = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PLAY   = 2'd1,
      REVEAL = 2'd2,
      WIN    = 2'd3
   } state_t;

endpackage

// File: rtl/fade_step_timer.sv
// Frame-paced fade level counter for a single tile reveal.
// done pulses combinationally on the tick that finishes the last level.
module fade_step_timer
   import tile_game_pkg::*;
#(
   parameter int STEPS  = FADE_STEPS,
   parameter int FRAMES = FRAMES_PER_STEP
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       enable,
   input  logic       screen_end,
   output logic [3:0] level,
   output logic       done
);

   localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

   logic [FW-1:0] frame_cnt;
   logic          tick;
   logic          frame_last;
   logic          level_last;

   assign tick       = enable & screen_end;
   assign frame_last = (frame_cnt == FW'(FRAMES - 1));
   assign level_last = (level == 4'(STEPS - 1));
   assign done       = tick & frame_last & level_last;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_cnt <= '0;
         level     <= '0;
      end else if (clear) begin
         frame_cnt <= '0;
         level     <= '0;
      end else if (tick) begin
         if (frame_last) begin
            frame_cnt <= '0;
            level     <= level_last ? 4'd0 : level + 4'd1;
         end else begin
            frame_cnt <= frame_cnt + FW'(1);
         end
      end
   end

endmodule

// File: rtl/tile_reveal_scheduler.sv
// Game-state controller: queues scored points and reveals grid tiles
// one at a time with a frame-synchronised fade.
module tile_reveal_scheduler
   import tile_game_pkg::*;
#(
   parameter int STEPS    = FADE_STEPS,
   parameter int FRAMES   = FRAMES_PER_STEP,
   parameter int PEND_LIM = PEND_MAX
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             point,
   input  logic             screen_end,
   output logic             ingame,
   output logic [31:0]      score,
   output logic [TILES-1:0] tile_mask,
   output logic [3:0]       reveal_tile,
   output logic [3:0]       reveal_level,
   output logic             busy,
   output logic             win
);

   localparam int PW = $clog2(PEND_LIM + 1);

   state_t           state, state_n;
   logic [31:0]      score_n;
   logic [TILES-1:0] mask_n;
   logic [PW-1:0]    pending, pending_n, pend_upd;
   logic [3:0]       tile_n;
   logic             clear;
   logic             done;
   logic             inc;

   fade_step_timer #(
      .STEPS  (STEPS),
      .FRAMES (FRAMES)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .enable     (state == REVEAL),
      .screen_end (screen_end),
      .level      (reveal_level),
      .done       (done)
   );

   always_comb begin
      state_n   = state;
      score_n   = score;
      mask_n    = tile_mask;
      tile_n    = reveal_tile;
      clear     = 1'b0;
      inc       = point && (state == PLAY || state == REVEAL);
      pend_upd  = pending;
      if (inc && !done && pending != PW'(PEND_LIM))
         pend_upd = pending + PW'(1);
      else if (done && !inc)
         pend_upd = pending - PW'(1);
      pending_n = pend_upd;

      if (start) begin
         state_n   = PLAY;
         score_n   = '0;
         mask_n    = '0;
         pending_n = '0;
         clear     = 1'b1;
      end else begin
         unique case (state)
            IDLE: ;
            PLAY: begin
               if (pending != '0 && score < TILES) begin
                  state_n = REVEAL;
                  tile_n  = score[3:0];
                  clear   = 1'b1;
               end
            end
            REVEAL: begin
               if (done) begin
                  mask_n[reveal_tile] = 1'b1;
                  score_n = score + 32'd1;
                  if (score_n == TILES) begin
                     state_n = WIN;
                  end else if (pend_upd != '0) begin
                     state_n = REVEAL;
                     tile_n  = score_n[3:0];
                  end else begin
                     state_n = PLAY;
                  end
               end
            end
            WIN: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         score       <= '0;
         tile_mask   <= '0;
         pending     <= '0;
         reveal_tile <= '0;
         ingame      <= 1'b0;
         busy        <= 1'b0;
         win         <= 1'b0;
      end else begin
         state       <= state_n;
         score       <= score_n;
         tile_mask   <= mask_n;
         pending     <= pending_n;
         reveal_tile <= tile_n;
         ingame      <= (state_n == PLAY) || (state_n == REVEAL);
         busy        <= (state_n == REVEAL);
         win         <= (state_n == WIN);
      end
   end

endmodule

// File: tb/tb_tile_reveal_scheduler.sv
// Self-checking bench for tile_reveal_scheduler.
// Vector table plus hand sequences for reset, saturation, win and abort.
module tb_tile_reveal_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        point = 1'b0;
   logic        screen_end = 1'b0;
   logic        ingame;
   logic [31:0] score;
   logic [11:0] tile_mask;
   logic [3:0]  reveal_tile;
   logic [3:0]  reveal_level;
   logic        busy;
   logic        win;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int          score;
      logic [11:0] mask;
      logic        busy;
      logic        ingame;
      logic        win;
   } exp_t;

   typedef struct {
      int   npoints;
      int   nframes;
      exp_t exp;
   } vec_t;

   exp_t sb[$];
   vec_t vt[6];

   tile_reveal_scheduler dut (
      .clk          (clk),
      .reset        (rst_n),
      .start        (start),
      .point        (point),
      .screen_end   (screen_end),
      .ingame       (ingame),
      .score        (score),
      .tile_mask    (tile_mask),
      .reveal_tile  (reveal_tile),
      .reveal_level (reveal_level),
      .busy         (busy),
      .win          (win)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic points(int n);
      if (n > 0) begin
         @(negedge clk);
         point = 1'b1;
         repeat (n) @(negedge clk);
         point = 1'b0;
      end
   endtask

   task automatic frames(int n);
      repeat (n) begin
         @(negedge clk);
         screen_end = 1'b1;
         @(negedge clk);
         screen_end = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      vt[0] = '{1, 32, '{1, 12'h001, 1'b0, 1'b1, 1'b0}};
      vt[1] = '{2, 64, '{3, 12'h007, 1'b0, 1'b1, 1'b0}};
      vt[2] = '{1, 31, '{3, 12'h007, 1'b1, 1'b1, 1'b0}};
      vt[3] = '{0, 1,  '{4, 12'h00F, 1'b0, 1'b1, 1'b0}};
      vt[4] = '{0, 10, '{4, 12'h00F, 1'b0, 1'b1, 1'b0}};
      vt[5] = '{3, 96, '{7, 12'h07F, 1'b0, 1'b1, 1'b0}};

      idle(3);
      chk("rst_score", score, 0);
      chk("rst_mask", tile_mask, 0);
      chk("rst_ingame", ingame, 0);
      chk("rst_busy", busy, 0);
      chk("rst_win", win, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // table-driven vectors with scoreboard
      pulse_start();
      chk("start_ingame", ingame, 1);
      for (int i = 0; i < 6; i++) begin
         points(vt[i].npoints);
         if (vt[i].npoints > 0) idle(2);
         sb.push_back(vt[i].exp);
         frames(vt[i].nframes);
         if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL sb_empty: got 0 entries expected 1");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("v%0d_score", i), score, e.score);
            chk($sformatf("v%0d_mask", i), tile_mask, e.mask);
            chk($sformatf("v%0d_busy", i), busy, e.busy);
            chk($sformatf("v%0d_ingame", i), ingame, e.ingame);
            chk($sformatf("v%0d_win", i), win, e.win);
         end
      end

      // fade level stepping
      pulse_start();
      points(1);
      idle(2);
      chk("fade_busy", busy, 1);
      chk("fade_tile", reveal_tile, 0);
      chk("fade_lvl0", reveal_level, 0);
      for (int i = 1; i < 32; i++) begin
         frames(1);
         chk($sformatf("fade_lvl_p%0d", i), reveal_level, i / 2);
      end
      chk("fade_busy31", busy, 1);
      frames(1);
      chk("fade_score", score, 1);
      chk("fade_mask", tile_mask, 12'h001);
      chk("fade_done_busy", busy, 0);

      // pending saturation
      pulse_start();
      points(9);
      idle(2);
      frames(256);
      chk("sat_score", score, 7);
      chk("sat_mask", tile_mask, 12'h07F);
      chk("sat_busy", busy, 0);
      chk("sat_ingame", ingame, 1);

      // point coincident with commit
      pulse_start();
      points(1);
      idle(2);
      frames(31);
      @(negedge clk);
      screen_end = 1'b1;
      point = 1'b1;
      @(negedge clk);
      screen_end = 1'b0;
      point = 1'b0;
      chk("coin_score", score, 1);
      chk("coin_busy", busy, 1);
      chk("coin_tile", reveal_tile, 1);
      chk("coin_lvl", reveal_level, 0);
      idle(1);
      frames(32);
      chk("coin_score2", score, 2);
      chk("coin_mask2", tile_mask, 12'h003);
      chk("coin_busy2", busy, 0);
      frames(32);
      chk("coin_score3", score, 2);

      // win
      pulse_start();
      points(7);
      idle(2);
      frames(224);
      points(4);
      idle(2);
      frames(128);
      chk("win_pre_score", score, 11);
      chk("win_pre_mask", tile_mask, 12'h7FF);
      points(1);
      idle(2);
      frames(32);
      chk("win_score", score, 12);
      chk("win_mask", tile_mask, 12'hFFF);
      chk("win_win", win, 1);
      chk("win_ingame", ingame, 0);
      chk("win_busy", busy, 0);
      points(1);
      idle(2);
      frames(32);
      chk("win_ign_score", score, 12);
      chk("win_ign_busy", busy, 0);
      pulse_start();
      chk("win_rst_score", score, 0);
      chk("win_rst_ingame", ingame, 1);
      chk("win_rst_win", win, 0);
      chk("win_rst_mask", tile_mask, 0);

      // start aborts a reveal
      pulse_start();
      points(1);
      idle(2);
      frames(18);
      chk("abort_lvl", reveal_level, 9);
      chk("abort_pre_busy", busy, 1);
      pulse_start();
      chk("abort_busy", busy, 0);
      chk("abort_score", score, 0);
      chk("abort_mask", tile_mask, 0);
      chk("abort_ingame", ingame, 1);
      chk("abort_lvl0", reveal_level, 0);
      idle(3);
      chk("abort_pend", busy, 0);

      // asynchronous reset mid-reveal
      pulse_start();
      points(6);
      idle(2);
      frames(160);
      chk("ar_pre_score", score, 5);
      chk("ar_pre_busy", busy, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_score", score, 0);
      chk("ar_mask", tile_mask, 0);
      chk("ar_busy", busy, 0);
      chk("ar_ingame", ingame, 0);
      chk("ar_win", win, 0);
      chk("ar_tile", reveal_tile, 0);
      chk("ar_lvl", reveal_level, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      chk("ar_idle_ingame", ingame, 0);
      chk("ar_idle_busy", busy, 0);
      points(1);
      idle(2);
      chk("ar_idle_pt_busy", busy, 0);
      frames(4);
      chk("ar_idle_score", score, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
